// File: rtl/mode_switch_ctrl.sv
// Glitch-free waveform-mode sequencer: debounces the mode key, steps the target
// mode, and applies it behind a fade-out / phase-wrap / fade-in gain envelope.
module mode_switch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int WRAP_TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       modekey,
    input  logic       sample_tick,
    input  logic       phase_wrap,
    output logic [1:0] mode,
    output logic [1:0] target_mode,
    output logic [3:0] gain,
    output logic       mode_changed,
    output logic       busy
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W = ($clog2(WRAP_TIMEOUT + 1) > 8) ? $clog2(WRAP_TIMEOUT + 1) : 8;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WRAP_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FADE_OUT  = 3'd1,
        ST_WAIT_WRAP = 3'd2,
        ST_SWITCH    = 3'd3,
        ST_FADE_IN   = 3'd4
    } state_t;

    logic            sync1_r;
    logic            sync2_r;
    logic            key_db_r;
    logic            press_r;
    logic [DB_W-1:0] db_cnt_r;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_nxt_s;
    logic [3:0]      gain_r;
    logic [3:0]      gain_nxt_s;
    logic [1:0]      mode_r;
    logic [1:0]      mode_nxt_s;
    logic [1:0]      target_mode_r;
    logic [1:0]      target_nxt_s;
    logic            mode_changed_r;
    logic            mode_changed_nxt_s;
    logic            busy_r;

    // Key synchronizer and debounce; press fires for one cycle after key_db rises
    always_ff @(posedge clk) begin
        if (n_rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            key_db_r <= 1'b0;
            press_r  <= 1'b0;
            db_cnt_r <= '0;
        end else begin
            sync1_r <= modekey;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == key_db_r) begin
                db_cnt_r <= '0;
            end else if (db_cnt_r == DB_LAST) begin
                key_db_r <= sync2_r;
                db_cnt_r <= '0;
                press_r  <= sync2_r;
            end else begin
                db_cnt_r <= db_cnt_r + DB_ONE;
            end
        end
    end

    // State register plus registered outputs
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_r        <= ST_IDLE;
            to_cnt_r       <= '0;
            gain_r         <= 4'd15;
            mode_r         <= 2'd0;
            target_mode_r  <= 2'd0;
            mode_changed_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            to_cnt_r       <= to_cnt_nxt_s;
            gain_r         <= gain_nxt_s;
            mode_r         <= mode_nxt_s;
            target_mode_r  <= target_nxt_s;
            mode_changed_r <= mode_changed_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (press_r) state_nxt_s = ST_FADE_OUT;
                else         state_nxt_s = ST_IDLE;
            end
            ST_FADE_OUT: begin
                // A tick at gain 1 lands on 0; a tick at gain 0 just moves on
                if (sample_tick && (gain_r <= 4'd1)) state_nxt_s = ST_WAIT_WRAP;
                else                                 state_nxt_s = ST_FADE_OUT;
            end
            ST_WAIT_WRAP: begin
                if (phase_wrap || (sample_tick && (to_cnt_r >= TO_LAST))) state_nxt_s = ST_SWITCH;
                else                                                      state_nxt_s = ST_WAIT_WRAP;
            end
            ST_SWITCH: begin
                state_nxt_s = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (press_r)                                 state_nxt_s = ST_FADE_OUT;
                else if (sample_tick && (gain_r >= 4'd14))   state_nxt_s = ST_IDLE;
                else                                         state_nxt_s = ST_FADE_IN;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath/output next values; mode is committed on entry to SWITCH so it is valid during SWITCH
    always_comb begin
        gain_nxt_s         = gain_r;
        to_cnt_nxt_s       = to_cnt_r;
        mode_nxt_s         = mode_r;
        mode_changed_nxt_s = 1'b0;
        if (press_r) target_nxt_s = target_mode_r + 2'd1;
        else         target_nxt_s = target_mode_r;
        case (state_r)
            ST_IDLE: begin
                gain_nxt_s = 4'd15;
            end
            ST_FADE_OUT: begin
                to_cnt_nxt_s = '0;
                if (sample_tick && (gain_r != 4'd0)) gain_nxt_s = gain_r - 4'd1;
                else                                 gain_nxt_s = gain_r;
            end
            ST_WAIT_WRAP: begin
                gain_nxt_s = 4'd0;
                if (state_nxt_s == ST_SWITCH) begin
                    mode_nxt_s         = target_nxt_s;
                    mode_changed_nxt_s = (target_nxt_s != mode_r);
                end else if (sample_tick) begin
                    to_cnt_nxt_s = to_cnt_r + TO_ONE;
                end else begin
                    to_cnt_nxt_s = to_cnt_r;
                end
            end
            ST_SWITCH: begin
                gain_nxt_s = gain_r;
            end
            ST_FADE_IN: begin
                if (!press_r && sample_tick && (gain_r != 4'd15)) gain_nxt_s = gain_r + 4'd1;
                else                                             gain_nxt_s = gain_r;
            end
            default: begin
                gain_nxt_s = 4'd15;
            end
        endcase
    end

    assign mode         = mode_r;
    assign target_mode  = target_mode_r;
    assign gain         = gain_r;
    assign mode_changed = mode_changed_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Self-checking bench for mode_switch_ctrl: applied modes are scoreboarded on each
// mode_changed pulse; gain ramps, latency, timeout and reset are checked directly.
module tb_mode_switch_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       modekey;
    logic       sample_tick;
    logic       phase_wrap;
    logic [1:0] mode;
    logic [1:0] target_mode;
    logic [3:0] gain;
    logic       mode_changed;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;
    int mc_cnt = 0;
    int tph = 0;
    int key_hold = 0;
    logic tick_en = 1'b1;
    logic tick_seen = 1'b0;
    logic [1:0] exp_q[$];

    mode_switch_ctrl #(.DEBOUNCE_CYCLES(4), .WRAP_TIMEOUT(8)) dut (
        .clk(clk), .n_rst(n_rst), .modekey(modekey), .sample_tick(sample_tick),
        .phase_wrap(phase_wrap), .mode(mode), .target_mode(target_mode), .gain(gain),
        .mode_changed(mode_changed), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every mode_changed pulse must match the next queued mode
    always @(negedge clk) begin
        if (mode_changed === 1'b1) begin
            mc_cnt <= mc_cnt + 1;
            if (exp_q.size() == 0) check_eq("no_mode_changed", mode_changed, 0);
            else                   check_eq("sb_mode", mode, exp_q.pop_front());
        end
    end

    // One clock: remember whether the edge sampled a tick, then drive the next inputs
    task automatic cyc();
        logic t;
        t = sample_tick;
        @(posedge clk);
        #1;
        tick_seen = t;
        tph = (tph == 2) ? 0 : tph + 1;
        sample_tick = tick_en && (tph == 2);
        phase_wrap = 1'b0;
        if (key_hold > 0) begin
            key_hold--;
            if (key_hold == 0) modekey = 1'b0;
        end
    endtask

    task automatic press_key();
        modekey = 1'b1;
        repeat (8) cyc();
        modekey = 1'b0;
        repeat (8) cyc();
    endtask

    task automatic wait_gain(input string tag, input int val, input int budget);
        int k = 0;
        while (gain != val && k < budget) begin
            cyc();
            k++;
        end
        check_eq(tag, gain, val);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            cyc();
            k++;
        end
        check_eq(tag, busy, 0);
        check_eq({tag, "_gain"}, gain, 15);
    endtask

    task automatic fade_down(input int start);
        int ex = start;
        int n = 0;
        int k = 0;
        while (gain != 0 && k < 200) begin
            cyc();
            k++;
            if (tick_seen) begin
                n++;
                ex--;
                check_eq("ramp_down", gain, ex);
            end
        end
        check_eq("down_ticks", n, start);
    endtask

    task automatic fade_up();
        int ex = 0;
        int n = 0;
        int k = 0;
        while (gain != 15 && k < 200) begin
            cyc();
            k++;
            if (tick_seen) begin
                n++;
                ex++;
                check_eq("ramp_up", gain, ex);
            end
        end
        check_eq("up_ticks", n, 15);
        check_eq("busy_fall", busy, 0);
    endtask

    initial begin
        int n;
        int sw;
        int k;
        int mc0;
        modekey = 1'b0; sample_tick = 1'b0; phase_wrap = 1'b0; n_rst = 1'b1;

        // Reset with a toggling key
        for (int i = 0; i < 2; i++) begin
            modekey = ~modekey;
            cyc();
        end
        modekey = 1'b0;
        n_rst = 1'b0;
        check_eq("rst_mode", mode, 0);
        check_eq("rst_target", target_mode, 0);
        check_eq("rst_gain", gain, 15);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mc", mode_changed, 0);

        // Bounce: 3 high / 1 low never survives 4 stable cycles
        for (int i = 0; i < 10; i++) begin
            modekey = 1'b1;
            repeat (3) cyc();
            modekey = 1'b0;
            cyc();
        end
        repeat (12) cyc();
        check_eq("bounce_target", target_mode, 0);
        check_eq("bounce_busy", busy, 0);

        // Single press: latency 2 + 4 edges after the first sampling edge
        modekey = 1'b1;
        key_hold = 10;
        repeat (6) cyc();
        check_eq("lat_early", busy, 0);
        cyc();
        check_eq("lat_busy", busy, 1);
        check_eq("lat_target", target_mode, 1);
        fade_down(15);
        n = 0;
        while (n < 5) begin
            cyc();
            if (tick_seen) n++;
        end
        check_eq("wait_mode", mode, 0);
        exp_q.push_back(2'd1);
        phase_wrap = 1'b1;
        cyc();
        check_eq("wrap_mode", mode, 1);
        check_eq("wrap_mc", mode_changed, 1);
        cyc();
        check_eq("mc_one_cycle", mode_changed, 0);
        fade_up();

        // Four presses: target returns to 1, no mode change
        mc0 = mc_cnt;
        repeat (4) press_key();
        check_eq("p4_target", target_mode, 1);
        wait_idle("p4_idle", 400);
        check_eq("p4_mode", mode, 1);
        check_eq("p4_no_pulse", mc_cnt - mc0, 0);

        // Reset while waiting for the wrap
        press_key();
        wait_gain("rst_wait_gain", 0, 200);
        repeat (2) cyc();
        check_eq("in_wait_busy", busy, 1);
        n_rst = 1'b1;
        cyc();
        n_rst = 1'b0;
        check_eq("mid_rst_mode", mode, 0);
        check_eq("mid_rst_target", target_mode, 0);
        check_eq("mid_rst_gain", gain, 15);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_mc", mode_changed, 0);
        repeat (10) cyc();
        check_eq("post_rst_busy", busy, 0);

        // Three presses from mode 0: one switch straight to 3
        mc0 = mc_cnt;
        repeat (3) press_key();
        check_eq("p3_target", target_mode, 3);
        exp_q.push_back(2'd3);
        wait_idle("p3_idle", 400);
        check_eq("p3_mode", mode, 3);
        check_eq("p3_one_pulse", mc_cnt - mc0, 1);

        // Timeout: switch on the 8th tick after gain reaches 0
        press_key();
        exp_q.push_back(2'd0);
        wait_gain("to_gain0", 0, 200);
        n = 0; sw = -1; k = 0;
        while (sw < 0 && k < 100) begin
            cyc();
            k++;
            if (tick_seen) n++;
            if (mode_changed) sw = n;
        end
        check_eq("to_tick", sw, 8);
        wait_idle("to_idle", 200);

        // Wrap and timeout in the same cycle: exactly one switch
        press_key();
        exp_q.push_back(2'd1);
        wait_gain("dual_gain0", 0, 200);
        n = 0;
        while (n < 7) begin
            cyc();
            if (tick_seen) n++;
        end
        k = 0;
        while (sample_tick == 1'b0 && k < 5) begin
            cyc();
            k++;
        end
        phase_wrap = 1'b1;
        mc0 = mc_cnt;
        cyc();
        check_eq("dual_mode", mode, 1);
        check_eq("dual_mc", mode_changed, 1);
        repeat (6) cyc();
        check_eq("dual_one_pulse", mc_cnt - mc0, 1);
        wait_idle("dual_idle", 200);

        // Press during fade-in at gain 7 resumes the fade-out from 7
        press_key();
        exp_q.push_back(2'd2);
        wait_gain("fi_gain0", 0, 200);
        repeat (2) cyc();
        phase_wrap = 1'b1;
        cyc();
        wait_gain("fi_gain7", 7, 100);
        tick_en = 1'b0;
        sample_tick = 1'b0;
        press_key();
        check_eq("fi_busy", busy, 1);
        check_eq("fi_target", target_mode, 3);
        check_eq("fi_hold7", gain, 7);
        tick_en = 1'b1;
        k = 0;
        tick_seen = 1'b0;
        while (!tick_seen && k < 10) begin
            cyc();
            k++;
        end
        check_eq("fi_step6", gain, 6);
        exp_q.push_back(2'd3);
        wait_idle("fi_idle", 400);
        check_eq("fi_mode", mode, 3);

        repeat (3) cyc();
        check_eq("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mode_switch_ctrl.md
# mode_switch_ctrl

Controller that sequences waveform-mode changes for the oscillator datapath. It debounces the raw mode key and advances a target mode through off → square → triangle → sawtooth → off. It then applies the change glitch-free: fade the output gain down, wait for an oscillator phase wrap, switch the mode, and fade the gain back up. It sits between the front-panel key input and the oscillator/mixer, replacing direct key-clocked mode registers.

## Interface
- DEBOUNCE_CYCLES, 10000: consecutive stable cycles required to accept a key level change; legal range ≥ 1.
- WRAP_TIMEOUT, 255: sample ticks to wait for phase_wrap before forcing the switch; legal range ≥ 1.
- clk  input  1  system clock; the only clock.
- n_rst  input  1  reset, synchronous, active-high.
- modekey  input  1  raw asynchronous mode key, active-high when pressed.
- sample_tick  input  1  one-cycle strobe at the audio sample rate.
- phase_wrap  input  1  one-cycle strobe when the oscillator phase accumulator wraps.
- mode  output  2  applied mode to the oscillator: 0 off, 1 square, 2 triangle, 3 sawtooth.
- target_mode  output  2  latest requested mode.
- gain  output  4  mixer gain, 0 = mute, 15 = full.
- mode_changed  output  1  one-cycle pulse when `mode` takes a new value.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Key input path:
  - 2-flop synchronizer on `modekey`, then a debounce counter.
  - The debounced level `key_db` changes only after the synchronized level differs from `key_db` for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle where the synchronized level matches `key_db` clears the counter.
- A press is the rising edge of `key_db`, giving a one-cycle internal `press`.
- Target update:
  - On `press`, `target_mode` ← `target_mode`+1, modulo 4 (3 wraps to 0).
  - This applies in every state, including the same cycle as a state transition.
- FSM states and transitions:
  - IDLE: `gain`=15. On `press` → FADE_OUT.
  - FADE_OUT: each `sample_tick` decrements `gain` by 1. On the tick that makes `gain`=0, → WAIT_WRAP and clear the timeout counter.
  - WAIT_WRAP: `gain` holds 0.
    - On `phase_wrap` → SWITCH.
    - Otherwise, each `sample_tick` increments the 8+-bit timeout counter; when it reaches WRAP_TIMEOUT → SWITCH.
    - If `phase_wrap` and the timeout hit in the same cycle, the transition still goes to SWITCH exactly once.
  - SWITCH: lasts one cycle. `mode` ← `target_mode`. `mode_changed`=1 only if the new value differs from the old one. Then → FADE_IN.
  - FADE_IN: each `sample_tick` increments `gain` by 1.
    - On the tick that makes `gain`=15 → IDLE.
    - A `press` in FADE_IN → FADE_OUT, ramping down from the current `gain` (no jump).
- A `press` during FADE_OUT or WAIT_WRAP only updates `target_mode`. The switch applies the latest target.
- Gain arithmetic: `gain` saturates; it never wraps below 0 or above 15.
- If FADE_OUT is entered with `gain`=0, the next `sample_tick` → WAIT_WRAP with no decrement.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values, applied at the next `clk` edge with `n_rst`=1:
  - state IDLE, `mode`=0, `target_mode`=0, `gain`=15.
  - `mode_changed`=0, `busy`=0.
  - Synchronizer flops, `key_db`, debounce counter and timeout counter all 0.
- Reset mid-operation aborts any fade or wait immediately; no partial switch is applied.
- All outputs are registered, with no combinational input-to-output paths.
- Press latency: `modekey` high at edge N → `press` internal at edge N+2+DEBOUNCE_CYCLES. `target_mode` and state update on that same edge.
- Each gain step lands on the clock edge that samples `sample_tick`=1. A full fade-out from 15 takes 15 ticks.
- SWITCH → FADE_IN: `mode` and `mode_changed` are valid in the cycle after the wrap or timeout is sampled.
- `phase_wrap` is ignored in every state except WAIT_WRAP.
- `sample_tick` is ignored in IDLE and SWITCH.

## Test plan
- Reset: assert `n_rst` 2 cycles with `modekey` toggling → `mode`=0, `target_mode`=0, `gain`=15, `busy`=0, no `mode_changed`.
- Single press, DEBOUNCE_CYCLES=4:
  - Stimulus: hold `modekey` 10 cycles; tick every 3 cycles; `phase_wrap` 5 ticks after `gain` reaches 0.
  - Required: `gain` 15→0 in 15 ticks; `mode`=1 with one `mode_changed` pulse; `gain` 0→15; `busy` falls.
- Bounce rejection: pulses of 3 cycles high / 1 cycle low for 40 cycles, then release → no `press`, `target_mode` stays 0.
- Multiple presses: 3 presses during FADE_OUT/WAIT_WRAP → `target_mode`=3, a single switch straight to `mode`=3.
  - 4 presses total from `mode`=0 → `mode` stays 0, no `mode_changed`, `gain` still returns to 15.
- Timeout: no `phase_wrap`, WRAP_TIMEOUT=8 → SWITCH on the 8th tick after `gain`=0.
  - Then `phase_wrap` and the 8th tick in the same cycle → exactly one switch.
- Press during FADE_IN at `gain`=7 → FADE_OUT resumes from 7, next tick gives 6.
  - Separately, `n_rst` asserted in WAIT_WRAP → all outputs return to their reset values on the next edge.
